// File: rtl/snes_mem_pkg.sv
// snes_mem_pkg: shared types and constants for the SNES memory front-ends
package snes_mem_pkg;
    localparam int ROM_ADDR_W = 24;
    // Controller acks at CAS and returns data at READ; CL3 RAS/CAS timing puts these 4 clocks apart
    localparam int ROM_DATA_DELAY = 4;

    typedef enum logic [2:0] {DRAIN, IDLE, WR_ACK, RD_ACK, RD_DATA} rom_state_t;

    function automatic logic [7:0] byte_lane(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction
endpackage

// File: rtl/toggle_req_port.sv
// toggle_req_port: toggle-handshake request line with completion detect
module toggle_req_port (
    input  logic i_clk,
    input  logic i_issue,
    input  logic i_ack,
    output logic o_req,
    output logic o_done
);
    // No reset: the controller's ack toggle survives our reset, so the request must too
    logic r_req;
    always_ff @(posedge i_clk)
        if (i_issue) r_req <= ~r_req;
    assign o_req = r_req;
    assign o_done = i_ack == r_req;
endmodule

// File: rtl/rom_port_bridge.sv
// rom_port_bridge: packs download bytes into ROM word writes and serves CPU byte reads
// through a one-word read buffer, over the controller's toggle-handshake ROM port.
module rom_port_bridge
    import snes_mem_pkg::*;
#(
    parameter int DATA_DELAY = ROM_DATA_DELAY
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dl_active,
    input  logic                  i_dl_wr,
    input  logic [ROM_ADDR_W-1:0] i_dl_addr,
    input  logic [7:0]            i_dl_data,
    output logic                  o_dl_busy,
    input  logic                  i_cpu_rd,
    input  logic [ROM_ADDR_W-1:0] i_cpu_addr,
    output logic [7:0]            o_cpu_dout,
    output logic                  o_cpu_ready,
    input  logic                  i_invalidate,
    output logic [ROM_ADDR_W-2:0] o_rom_addr,
    output logic [15:0]           o_rom_din,
    output logic                  o_rom_we,
    output logic                  o_rom_req,
    input  logic                  i_rom_req_ack,
    input  logic [15:0]           i_rom_dout
);
    localparam int CW = $clog2(DATA_DELAY + 1);

    rom_state_t            r_state;
    logic [7:0]            r_lo_byte;
    logic [ROM_ADDR_W-2:0] r_lo_addr;
    logic                  r_lo_valid;
    logic [15:0]           r_buf;
    logic [ROM_ADDR_W-2:0] r_tag;
    logic                  r_valid;
    logic                  r_inv;
    logic                  r_sel;
    logic [CW-1:0]         r_cnt;
    logic w_idle, w_wr_even, w_wr_odd, w_flush, w_rd, w_hit, w_miss, w_issue, w_done;

    always_comb begin
        w_idle    = r_state == IDLE && !i_reset;
        w_wr_even = w_idle && i_dl_wr && !i_dl_addr[0];
        w_wr_odd  = w_idle && i_dl_wr && i_dl_addr[0];
        // A pending low byte with the download no longer active is the tail of an odd-length image
        w_flush   = w_idle && !i_dl_wr && !i_dl_active && r_lo_valid;
        w_rd      = w_idle && !i_dl_wr && !w_flush && i_cpu_rd && !i_dl_active;
        w_hit     = w_rd && r_valid && r_tag == i_cpu_addr[ROM_ADDR_W-1:1];
        w_miss    = w_rd && !w_hit;
        w_issue   = w_wr_odd || w_flush || w_miss;
    end

    toggle_req_port u_req (
        .i_clk  (i_clk),
        .i_issue(w_issue),
        .i_ack  (i_rom_req_ack),
        .o_req  (o_rom_req),
        .o_done (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= DRAIN;
            o_dl_busy   <= 1'b1;
            o_cpu_ready <= 1'b0;
            o_cpu_dout  <= '0;
            o_rom_we    <= 1'b0;
            o_rom_addr  <= '0;
            o_rom_din   <= '0;
            r_valid     <= 1'b0;
            r_lo_valid  <= 1'b0;
            r_inv       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            o_cpu_ready <= 1'b0;
            if (i_invalidate || w_wr_even || w_wr_odd) r_valid <= 1'b0;
            if (i_invalidate) r_inv <= 1'b1;
            case (r_state)
                DRAIN, WR_ACK: if (w_done) begin
                    r_state   <= IDLE;
                    o_dl_busy <= 1'b0;
                end
                IDLE: begin
                    if (w_wr_even) begin
                        r_lo_byte  <= i_dl_data;
                        r_lo_addr  <= i_dl_addr[ROM_ADDR_W-1:1];
                        r_lo_valid <= 1'b1;
                    end
                    if (w_wr_odd || w_flush) begin
                        o_rom_we   <= 1'b1;
                        o_rom_addr <= w_wr_odd ? i_dl_addr[ROM_ADDR_W-1:1] : r_lo_addr;
                        o_rom_din  <= w_wr_odd ? {i_dl_data, r_lo_valid ? r_lo_byte : 8'h00}
                                               : {8'h00, r_lo_byte};
                        r_lo_valid <= 1'b0;
                        r_state    <= WR_ACK;
                        o_dl_busy  <= 1'b1;
                    end
                    if (w_hit) begin
                        o_cpu_dout  <= byte_lane(r_buf, i_cpu_addr[0]);
                        o_cpu_ready <= 1'b1;
                    end
                    if (w_miss) begin
                        o_rom_we   <= 1'b0;
                        o_rom_addr <= i_cpu_addr[ROM_ADDR_W-1:1];
                        r_sel      <= i_cpu_addr[0];
                        r_inv      <= i_invalidate;
                        r_state    <= RD_ACK;
                        o_dl_busy  <= 1'b1;
                    end
                end
                RD_ACK: if (w_done) begin
                    r_state <= RD_DATA;
                    r_cnt   <= '0;
                end
                RD_DATA: if (r_cnt == CW'(DATA_DELAY - 1)) begin
                    r_buf       <= i_rom_dout;
                    r_tag       <= o_rom_addr;
                    // An invalidate seen during this read still returns the word but must not keep it
                    r_valid     <= !(r_inv || i_invalidate);
                    o_cpu_dout  <= byte_lane(i_rom_dout, r_sel);
                    o_cpu_ready <= 1'b1;
                    r_state     <= IDLE;
                    o_dl_busy   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= DRAIN;
            endcase
        end
    end
endmodule

// File: doc/rom_port_bridge.md
# rom_port_bridge

Upstream front-end for the SDRAM controller's ROM port. It turns two byte-wide sources into 16-bit toggle-handshake requests on `rom_req`/`rom_req_ack`: the ROM download stream (`dl_*`) and the cartridge CPU read strobe (`cpu_*`). Download bytes are packed into words before being written. CPU reads go through a one-word read buffer, so repeated byte reads of the same word do not touch SDRAM.

## Interface
- `DATA_DELAY`, default 4: clocks from observing `rom_req_ack == rom_req` to `rom_dout` being valid. The controller acks at CAS and returns data at READ, which is 4 clocks later.
- `clk` in 1: SDRAM clock, shared with the controller.
- `reset` in 1: synchronous, active-high.
- `dl_active` in 1: download in progress. While high, the bridge owns the port for writes.
- `dl_wr` in 1: one-cycle byte-write strobe.
- `dl_addr` in 24: byte address.
- `dl_data` in 8: byte data.
- `dl_busy` out 1: source must hold off `dl_wr` while this is high.
- `cpu_rd` in 1: one-cycle read strobe.
- `cpu_addr` in 24: byte address.
- `cpu_dout` out 8: read byte.
- `cpu_ready` out 1: one-cycle pulse; `cpu_dout` is valid in the same cycle.
- `invalidate` in 1: clears the read buffer.
- `rom_addr` out 23: word address [23:1].
- `rom_din` out 16: write word.
- `rom_we` out 1: request is a write.
- `rom_req` out 1: request toggle.
- `rom_req_ack` in 1: acknowledge toggle from the controller.
- `rom_dout` in 16: read word from the controller.

## Operation
- FSM states: DRAIN, IDLE, WR_ACK, RD_ACK, RD_DATA.
- A request is issued by registering `rom_addr`, `rom_we` and `rom_din`, then toggling `rom_req`. It completes when `rom_req_ack == rom_req`.
- Byte lanes: `addr[0]=0` is `[7:0]`, `addr[0]=1` is `[15:8]`.
- Download path:
  - `dl_wr` with `dl_addr[0]=0`: latch the byte as the pending low byte and set `lo_valid`. No request is issued.
  - `dl_wr` with `dl_addr[0]=1`: form `{dl_data, lo_byte}` at word `dl_addr[23:1]`, issue a write, go to WR_ACK, set `dl_busy`, clear `lo_valid`.
  - On ack, return to IDLE and clear `dl_busy`.
  - If the odd byte arrives without a pending low byte, the low byte is written as 0x00.
- Download flush: on a falling edge of `dl_active` with `lo_valid` set, write `{8'h00, lo_byte}` to the last even word, then return to IDLE.
- Download invalidation: any download write clears the read buffer valid bit.
- CPU read, accepted only in IDLE with `dl_active=0`:
  - Hit: buffer valid and `tag == cpu_addr[23:1]`. `cpu_dout` gets the buffered byte and `cpu_ready` pulses on the next cycle. No SDRAM request is issued.
  - Miss: issue a read, go to RD_ACK. On ack, go to RD_DATA and count `DATA_DELAY` clocks. At the end of the count, latch `rom_dout` into the buffer, set the tag and valid bit, drive the selected byte on `cpu_dout`, pulse `cpu_ready`, and return to IDLE.
- Ignored strobes: `cpu_rd` outside IDLE, or while `dl_active`, is dropped; no `cpu_ready` follows. `dl_wr` while `dl_busy` is dropped, which is a source protocol violation.
- `invalidate` clears valid in any state. If it arrives during RD_DATA, the word still completes the current read but is not kept as valid.

## Timing
- Reset values: `cpu_ready=0`, `cpu_dout=0`, `dl_busy=1` (while in DRAIN), `rom_we=0`, `rom_addr=0`, `rom_din=0`, buffer invalid, `lo_valid=0`.
- `rom_req` is not modified by reset, because the controller's ack is not reset. After reset the FSM enters DRAIN and waits for `rom_req_ack == rom_req`, then goes to IDLE with `dl_busy=0`. A request in flight at reset therefore completes harmlessly and is discarded.
- Hit latency: `cpu_rd` in cycle N gives `cpu_ready` in cycle N+1.
- Miss latency: ack seen in cycle A gives `cpu_ready` in cycle A+`DATA_DELAY`+1.
- Only one request is outstanding at a time, and `rom_req` toggles at most once per request.

## Structure
- Shared package `snes_mem_pkg`:
  - FSM state enum.
  - `ROM_ADDR_W=24`.
  - `ROM_DATA_DELAY=4`, tied to the controller's CL3 RAS/CAS timing; this constant should move to the package.
- Optional sub-module `toggle_req_port`: request toggle plus completion detect, reusable later for the WRAM/ARAM/BSRAM front-ends.
- Target size: about 200 lines of RTL.

## Test plan
- Download bytes 0x11@0x000000, 0x22@0x000001 → one write, `rom_addr=0`, `rom_din=0x2211`, `rom_we=1`; `dl_busy` high until ack.
- Odd byte count: 0x33@0x000004 followed by `dl_active` falling → flush write at `rom_addr=2` with `rom_din=0x0033`.
- CPU read 0x000001 (miss, model returns 0xBEEF) → `cpu_dout=0xBE`, `cpu_ready` exactly 5 clocks after ack; then read 0x000000 → `cpu_dout=0xEF` next cycle with no `rom_req` toggle.
- `invalidate` or a download write between two reads of the same word → the second read misses and issues a new request.
- `cpu_rd` during RD_ACK, and during `dl_active` → no extra `rom_req` toggle, no `cpu_ready`.
- Assert `reset` in RD_ACK with the ack still pending → `rom_req` unchanged, FSM held in DRAIN until the ack arrives, no `cpu_ready`, then normal operation resumes.
